// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode and sequencer state types shared by the command sequencer
package alu_pkg;
  typedef enum logic [3:0] {
    NOP  = 4'h0,
    ADD  = 4'h1,
    SUB  = 4'h2,
    MUL  = 4'h3,
    DIV  = 4'h4,
    AND  = 4'h6,
    OR   = 4'h7,
    XOR  = 4'h8,
    NOT  = 4'h9,
    NAND = 4'hA,
    NOR  = 4'hB,
    XNOR = 4'hC,
    SHL  = 4'hD,
    SHR  = 4'hE
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} seq_state_e;
  function automatic logic is_legal_op(input logic [3:0] op);
    return op != 4'h5 && op != 4'hF;
  endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO with full/empty flags
module alu_cmd_fifo #(
  parameter int W     = 72,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: FIFO-buffered ALU command issuer with tagged responses; ALU_SEQ_DIV0_CHECK_EN traps DIV by zero locally
module alu_op_sequencer import alu_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 4,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_err,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);
  localparam int EW = 2*DATA_W + OP_W + TAG_W;
  localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
  logic [EW-1:0] head;
  logic [DATA_W-1:0] h_a, h_b, trap_data;
  logic [OP_W-1:0] h_op;
  logic [TAG_W-1:0] h_tag, tag_q;
  logic full, empty, pop, trap;
  logic [CW-1:0] cnt;
  seq_state_e state;
  alu_cmd_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(cmd_valid), .pop(pop),
    .wr_data({cmd_tag, cmd_op, cmd_b, cmd_a}), .rd_data(head),
    .full(full), .empty(empty)
  );
  assign {h_tag, h_op, h_b, h_a} = head;
  assign cmd_ready = !full;
  assign busy      = state != IDLE || !empty;
  assign pop       = !empty && (state == IDLE || (state == RESP && rsp_ready));
`ifdef ALU_SEQ_DIV0_CHECK_EN
  logic div0;
  assign div0      = h_op == OP_W'(DIV) && h_b == '0;
  assign trap      = !is_legal_op(h_op) || div0;
  assign trap_data = div0 ? '1 : '0;
`else
  assign trap      = !is_legal_op(h_op);
  assign trap_data = '0;
`endif
  // trapped commands skip the ALU and answer on the cycle after the pop
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      tag_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      if (state == ISSUE) begin
        if (cnt == '0) begin
          state      <= RESP;
          rsp_valid  <= 1'b1;
          rsp_data   <= alu_c;
          rsp_err    <= alu_err;
          rsp_tag    <= tag_q;
          alu_opcode <= '0;
        end else cnt <= cnt - 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        state     <= IDLE;
      end
      if (pop) begin
        if (trap) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= trap_data;
          rsp_err   <= 1'b1;
          rsp_tag   <= h_tag;
        end else begin
          state      <= ISSUE;
          alu_a      <= h_a;
          alu_b      <= h_b;
          alu_opcode <= h_op;
          tag_q      <= h_tag;
          cnt        <= CW'(ALU_LAT - 1);
        end
      end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized and directed checks of the sequencer against a queue-based response model
module tb_alu_op_sequencer;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic cmd_ready, rsp_valid, rsp_err, busy, alu_err;
  logic [31:0] cmd_a = '0, cmd_b = '0, alu_a, alu_b, alu_c, rsp_data;
  logic [3:0] cmd_op = '0, cmd_tag = '0, alu_opcode, rsp_tag;
  typedef struct {logic [31:0] data; logic err; logic [3:0] tag;} exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0, bad_issue = 0, div0_issued = 0, unstable = 0;
  logic hold_v = 1'b0;
  logic [36:0] hold_r = '0;
  logic done = 1'b0;
  logic [31:0] ra, rb;
  logic [3:0] rop;
  exp_t e;
  always #5 clk = ~clk;
  alu_op_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_c(alu_c), .alu_err(alu_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_tag(rsp_tag), .busy(busy)
  );
  // behavioural stand-in for the ALU: answers within the issue cycle
  function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0: return {1'b0, 32'h0};
      4'h1: return {1'b0, a + b};
      4'h2: return {1'b0, a - b};
      4'h3: return {1'b0, a * b};
      4'h4: return b == 0 ? {1'b1, 32'h0} : {1'b0, a / b};
      4'h6: return {1'b0, a & b};
      4'h7: return {1'b0, a | b};
      4'h8: return {1'b0, a ^ b};
      4'h9: return {1'b0, ~a};
      4'hA: return {1'b0, ~(a & b)};
      4'hB: return {1'b0, ~(a | b)};
      4'hC: return {1'b0, ~(a ^ b)};
      4'hD: return {1'b0, a << b[4:0]};
      4'hE: return {1'b0, a >> b[4:0]};
      default: return {1'b1, 32'h0};
    endcase
  endfunction
  assign {alu_err, alu_c} = alu_fn(alu_opcode, alu_a, alu_b);
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic [3:0] tag);
    exp_t r;
    r.tag = tag;
    {r.err, r.data} = alu_fn(op, a, b);
    if (op == 4'h5 || op == 4'hF) begin
      r.err  = 1'b1;
      r.data = 32'h0;
    end
`ifdef ALU_SEQ_DIV0_CHECK_EN
    if (op == 4'h4 && b == 0) begin
      r.err  = 1'b1;
      r.data = 32'hFFFF_FFFF;
    end
`endif
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic [3:0] tag);
    int n;
    n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("cmd_accept_timeout", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    exp_q.push_back(model(a, b, op, tag));
    #1 cmd_valid = 1'b0;
  endtask
  task automatic wait_rsp();
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_wait", 64'(rsp_valid), 64'(1));
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1 chk("drain", 64'(exp_q.size()), 64'(0));
  endtask
  always @(negedge clk)
    if (reset) hold_v = 1'b0;
    else begin
      if (alu_opcode == 4'h5 || alu_opcode == 4'hF) bad_issue++;
      if (alu_opcode == 4'h4 && alu_b == 0) div0_issued++;
      if (rsp_valid && hold_v && {rsp_data, rsp_err, rsp_tag} != hold_r) unstable++;
      hold_v = rsp_valid && !rsp_ready;
      hold_r = {rsp_data, rsp_err, rsp_tag};
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_extra", 64'(rsp_tag), 64'(16));
        else begin
          e = exp_q.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
        end
      end
    end
  initial begin
    exp_t x;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_alu_opcode", 64'(alu_opcode), 64'(0));
    chk("rst_alu_a", 64'(alu_a), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    reset = 1'b0;
    step();
    rsp_ready = 1'b1;
    send(32'h10, 32'h20, 4'h1, 4'h3);
    @(negedge clk) chk("lat_e0", 64'(rsp_valid), 64'(0));
    @(negedge clk) chk("lat_e1", 64'(rsp_valid), 64'(0));
    @(negedge clk) chk("lat_e2", 64'(rsp_valid), 64'(1));
    chk("lat_data", 64'(rsp_data), 64'(32'h30));
    step();
    drain();
    rsp_ready = 1'b0;
    send(32'h10, 32'h20, 4'h1, 4'h1);
    send(32'h20, 32'h10, 4'h2, 4'h2);
    send(32'hFF, 32'hFF00, 4'h6, 4'h3);
    send(32'hFF, 32'hFF00, 4'h7, 4'h4);
    send(32'h1, 32'h1, 4'hD, 4'h5);
    @(negedge clk);
    chk("full_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("full_busy", 64'(busy), 64'(1));
    step();
    rsp_ready = 1'b1;
    drain();
    rsp_ready = 1'b0;
    send(32'h1, 32'h2, 4'h5, 4'h7);
    wait_rsp();
    chk("illegal_opcode", 64'(alu_opcode), 64'(0));
    chk("illegal_data", 64'(rsp_data), 64'(0));
    chk("illegal_err", 64'(rsp_err), 64'(1));
    chk("illegal_tag", 64'(rsp_tag), 64'(7));
    step();
    rsp_ready = 1'b1;
    drain();
    rsp_ready = 1'b0;
    div0_issued = 0;
    send(32'h4, 32'h0, 4'h4, 4'h2);
    wait_rsp();
`ifdef ALU_SEQ_DIV0_CHECK_EN
    chk("div0_data", 64'(rsp_data), 64'(32'hFFFF_FFFF));
    chk("div0_err", 64'(rsp_err), 64'(1));
    chk("div0_issued", 64'(div0_issued > 0), 64'(0));
`else
    chk("div0_data", 64'(rsp_data), 64'(0));
    chk("div0_err", 64'(rsp_err), 64'(1));
    chk("div0_issued", 64'(div0_issued > 0), 64'(1));
`endif
    step();
    rsp_ready = 1'b1;
    drain();
    rsp_ready = 1'b0;
    x = model(32'hFF, 32'hFF00, 4'hC, 4'h9);
    send(32'hFF, 32'hFF00, 4'hC, 4'h9);
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_data", 64'(rsp_data), 64'(x.data));
      chk("hold_opcode", 64'(alu_opcode), 64'(0));
    end
    step();
    rsp_ready = 1'b1;
    drain();
    rsp_ready = 1'b0;
    send(32'h3, 32'h4, 4'h1, 4'h1);
    send(32'h5, 32'h6, 4'h3, 4'h2);
    send(32'h7, 32'h8, 4'h3, 4'h3);
    send(32'h9, 32'hA, 4'h3, 4'h4);
    wait_rsp();
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("pre_reset_issue", 64'(alu_opcode), 64'(3));
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_opcode", 64'(alu_opcode), 64'(0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_alu_a", 64'(alu_a), 64'(0));
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      chk("post_rst_rsp", 64'(seen), 64'(0));
    end
    step();
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          rop = 4'($urandom_range(0, 15));
          ra  = $urandom;
          rb  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
          send(ra, rb, rop, 4'(i));
          if ($urandom_range(0, 2) == 0) step();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    drain();
    chk("illegal_issued", 64'(bad_issue), 64'(0));
    chk("rsp_unstable", 64'(unstable), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
